// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit pattern plus a repeat count over
// valid/ready and shifts it out MSB-first, one bit per clock, back-to-back.
module seq_pattern_tx #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic             abort,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] REP_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);
    localparam logic [WIDTH-1:0] PAT_ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] pat_r;
    logic [WIDTH-1:0] pat_s;
    logic [CNT_W-1:0] rep_left_r;
    logic [CNT_W-1:0] rep_left_s;
    logic [BIT_W-1:0] bit_idx_r;
    logic [BIT_W-1:0] bit_idx_s;

    logic dout_s;
    logic dout_valid_s;
    logic busy_s;
    logic done_s;
    logic load_ready_s;

    logic dout_r;
    logic dout_valid_r;
    logic busy_r;
    logic done_r;
    logic load_ready_r;

    // Bit idx of the current repetition, counted from the MSB.
    function automatic logic pick_bit(input logic [WIDTH-1:0] pat,
                                      input logic [BIT_W-1:0] idx);
        return pat[LAST_BIT - idx];
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            pat_r      <= PAT_ZERO;
            rep_left_r <= REP_ZERO;
            bit_idx_r  <= BIT_ZERO;
        end else begin
            state_r    <= state_s;
            pat_r      <= pat_s;
            rep_left_r <= rep_left_s;
            bit_idx_r  <= bit_idx_s;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_s    = state_r;
        pat_s      = pat_r;
        rep_left_s = rep_left_r;
        bit_idx_s  = bit_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (load_valid) begin
                    pat_s      = pattern;
                    rep_left_s = repeat_cnt;
                    bit_idx_s  = BIT_ZERO;
                    if (repeat_cnt != REP_ZERO) begin
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_DONE;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                // abort outranks completion; the bit on the wire this cycle still counts
                if (abort) begin
                    state_s    = ST_IDLE;
                    rep_left_s = REP_ZERO;
                    bit_idx_s  = BIT_ZERO;
                end else if (bit_idx_r == LAST_BIT) begin
                    bit_idx_s  = BIT_ZERO;
                    rep_left_s = rep_left_r - REP_ONE;
                    if (rep_left_r == REP_ONE) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_SEND;
                    end
                end else begin
                    bit_idx_s = bit_idx_r + BIT_ONE;
                    state_s   = ST_SEND;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s    = ST_IDLE;
                rep_left_s = REP_ZERO;
                bit_idx_s  = BIT_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so the ports can be registered.
    always_comb begin
        dout_s       = 1'b0;
        dout_valid_s = 1'b0;
        busy_s       = 1'b0;
        done_s       = 1'b0;
        load_ready_s = 1'b0;
        case (state_s)
            ST_IDLE: begin
                load_ready_s = 1'b1;
            end
            ST_SEND: begin
                busy_s       = 1'b1;
                dout_valid_s = 1'b1;
                dout_s       = pick_bit(pat_s, bit_idx_s);
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                load_ready_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            dout_r       <= 1'b0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            load_ready_r <= 1'b1;
        end else begin
            dout_r       <= dout_s;
            dout_valid_r <= dout_valid_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            load_ready_r <= load_ready_s;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign load_ready = load_ready_r;

endmodule
